// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse receive path: FSM state encodings,
// error-code bit positions and the default inter-edge timeout.
package mouse_pkg;

   // Receiver FSM states. The encoding is also exported as a debug port.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DATA   = 3'd1,
      PARITY = 3'd2,
      STOP   = 3'd3,
      DONE   = 3'd4
   } rx_state_t;

   // Bit positions inside BYTE_ERROR_CODE.
   localparam int PAR_ERR  = 0;
   localparam int STOP_ERR = 1;

   // 500 us at a 100 MHz system clock.
   localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

   // Value the parity bit must take so that data plus parity has odd weight.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line, followed by a falling-edge
// detector on the synchronised value. Lines idle high, so every flop resets
// to 1 to avoid a spurious edge when reset is released.
module ps2_line_sync (
   input  logic CLK,
   input  logic RESETN,
   input  logic line_raw,
   output logic line_synced,
   output logic fall_edge
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchroniser chain plus one history flop for edge detection.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so each flop takes its neighbour's pre-edge value; blocking would collapse the chain into one stage.
         meta_q <= line_raw;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign line_synced = sync_q;
   assign fall_edge   = prev_q & ~sync_q;

endmodule

// File: rtl/mouse_receiver.sv
// Host-side PS/2 receiver. Observes the mouse clock and data lines, shifts in
// an 11-bit device-to-host frame (start, D0..D7 LSB first, odd parity, stop),
// publishes the byte with parity/stop error flags and pulses BYTE_READY once.
module mouse_receiver
   import mouse_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       CLK_MOUSE_IN,
   input  logic       DATA_MOUSE_IN,
   input  logic       READ_ENABLE,
   output logic [7:0] BYTE_READ,
   output logic [1:0] BYTE_ERROR_CODE,
   output logic       BYTE_READY,
   output logic [2:0] MSReceiverState
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

   // Synchronised line views.
   logic clk_fall;
   logic clk_synced_unused;
   logic data_synced;
   logic data_fall_unused;

   // FSM state and datapath registers.
   rx_state_t     state_q,   state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q,   shift_d;
   logic          parity_q,  parity_d;
   logic [TW-1:0] timer_q,   timer_d;
   logic [7:0]    byte_q,    byte_d;
   logic [1:0]    err_q,     err_d;
   logic          ready_q,   ready_d;

   logic in_frame;
   logic timed_out;

   ps2_line_sync u_clk_sync (
      .CLK         (CLK),
      .RESETN      (RESETN),
      .line_raw    (CLK_MOUSE_IN),
      .line_synced (clk_synced_unused),
      .fall_edge   (clk_fall)
   );

   ps2_line_sync u_data_sync (
      .CLK         (CLK),
      .RESETN      (RESETN),
      .line_raw    (DATA_MOUSE_IN),
      .line_synced (data_synced),
      .fall_edge   (data_fall_unused)
   );

   // The inter-edge watchdog only runs while a frame is being collected.
   assign in_frame  = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
   assign timed_out = in_frame && (timer_q == TIMEOUT_LIMIT);

   // Next-state and datapath update; abort sources override edge processing.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      timer_d   = '0;
      byte_d    = byte_q;
      err_d     = err_q;
      ready_d   = 1'b0;

      if (!READ_ENABLE) begin
         // Host transmitter owns the bus: drop any partial frame silently.
         state_d = IDLE;
      end else if (timed_out) begin
         // Mouse stopped clocking mid-frame: abandon it, keep old outputs.
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               // A falling edge with data high is line noise, not a start bit.
               if (clk_fall && !data_synced) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end
            end

            DATA: begin
               if (clk_fall) begin
                  shift_d   = {data_synced, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = PARITY;
                  end
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end

            PARITY: begin
               if (clk_fall) begin
                  parity_d = data_synced;
                  state_d  = STOP;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end

            STOP: begin
               if (clk_fall) begin
                  state_d          = DONE;
                  byte_d           = shift_q;
                  err_d[PAR_ERR]   = (parity_q != odd_parity(shift_q));
                  err_d[STOP_ERR]  = ~data_synced;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end

            DONE: begin
               // Outputs were loaded on entry; the strobe follows one edge later.
               ready_d = 1'b1;
               state_d = IDLE;
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q   <= IDLE;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'h00;
         parity_q  <= 1'b0;
         timer_q   <= '0;
         byte_q    <= 8'h00;
         err_q     <= 2'b00;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         timer_q   <= timer_d;
         byte_q    <= byte_d;
         err_q     <= err_d;
         ready_q   <= ready_d;
      end
   end

   assign BYTE_READ       = byte_q;
   assign BYTE_ERROR_CODE = err_q;
   assign BYTE_READY      = ready_q;
   assign MSReceiverState = state_q;

endmodule
